// File: rtl/knap_search_ctrl_if.sv
// rtl/knap_search_ctrl_if.sv - host/checker-facing signal bundle for knap_search_ctrl (optional KNAP_BEST_TRACK_EN fields)
interface knap_search_ctrl_if #(
  parameter int N_ITEMS = 5
`ifdef KNAP_BEST_TRACK_EN
  , parameter int VAL_W = 32
`endif
);
  logic               start;
  logic               abort;
  logic [N_ITEMS-1:0] sel;
  logic               chk_valid;
  logic               busy;
  logic               done;
  logic               res_valid;
  logic               found;
  logic [N_ITEMS-1:0] first_sel;
  logic [N_ITEMS:0]   count;
`ifdef KNAP_BEST_TRACK_EN
  logic [VAL_W-1:0]   chk_value;
  logic [N_ITEMS-1:0] best_sel;
  logic [VAL_W-1:0]   best_value;

  modport master (
    output start, abort, chk_valid, chk_value,
    input  sel, busy, done, res_valid, found, first_sel, count, best_sel, best_value
  );
  modport slave (
    input  start, abort, chk_valid, chk_value,
    output sel, busy, done, res_valid, found, first_sel, count, best_sel, best_value
  );
`else
  modport master (
    output start, abort, chk_valid,
    input  sel, busy, done, res_valid, found, first_sel, count
  );
  modport slave (
    input  start, abort, chk_valid,
    output sel, busy, done, res_valid, found, first_sel, count
  );
`endif
endinterface

// File: rtl/knap_search_ctrl.sv
// rtl/knap_search_ctrl.sv - brute-force subset sweeper for the knapsack checker; KNAP_BEST_TRACK_EN adds best-value tracking
module knap_search_ctrl #(
  parameter int N_ITEMS = 5
`ifdef KNAP_BEST_TRACK_EN
  , parameter int VAL_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  knap_search_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [N_ITEMS-1:0] LAST_SEL  = '1;
  localparam logic [N_ITEMS:0]   COUNT_ONE = (N_ITEMS+1)'(1);

  state_t             state;
  logic [N_ITEMS-1:0] sel_q;
  logic               busy_q;
  logic               done_q;
  logic               res_valid_q;
  logic               found_q;
  logic [N_ITEMS-1:0] first_sel_q;
  logic [N_ITEMS:0]   count_q;
`ifdef KNAP_BEST_TRACK_EN
  logic [N_ITEMS-1:0] best_sel_q;
  logic [VAL_W-1:0]   best_value_q;
`endif

  assign bus.sel       = sel_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.res_valid = res_valid_q;
  assign bus.found     = found_q;
  assign bus.first_sel = first_sel_q;
  assign bus.count     = count_q;
`ifdef KNAP_BEST_TRACK_EN
  assign bus.best_sel   = best_sel_q;
  assign bus.best_value = best_value_q;
`endif

  // Sweep sequencer: one candidate per clock, results accumulate while RUN, abort wins over the final sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sel_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      found_q     <= 1'b0;
      first_sel_q <= '0;
      count_q     <= '0;
`ifdef KNAP_BEST_TRACK_EN
      best_sel_q   <= '0;
      best_value_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= RUN;
            busy_q      <= 1'b1;
            sel_q       <= '0;
            count_q     <= '0;
            found_q     <= 1'b0;
            first_sel_q <= '0;
            res_valid_q <= 1'b0;
`ifdef KNAP_BEST_TRACK_EN
            best_sel_q   <= '0;
            best_value_q <= '0;
`endif
          end
        end
        RUN: begin
          if (bus.abort) begin
            // Partial results are left untouched; res_valid stays low so nobody trusts them.
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            if (bus.chk_valid) begin
              count_q <= count_q + COUNT_ONE;
              if (!found_q) begin
                first_sel_q <= sel_q;
                found_q     <= 1'b1;
              end
`ifdef KNAP_BEST_TRACK_EN
              // Strict greater-than keeps the lower index on ties since sel only increases.
              if (!found_q || (bus.chk_value > best_value_q)) begin
                best_sel_q   <= sel_q;
                best_value_q <= bus.chk_value;
              end
`endif
            end
            if (sel_q == LAST_SEL) begin
              // sel parks at all-ones; no wrap back to zero.
              state       <= DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              res_valid_q <= 1'b1;
            end else begin
              sel_q <= sel_q + 1'b1;
            end
          end
        end
        DONE: begin
          // start is not looked at here, so a held start only relaunches from IDLE.
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_knap_search_ctrl.sv
// tb/tb_knap_search_ctrl.sv - self-checking bench for knap_search_ctrl against a table-scan reference model
module tb_knap_search_ctrl;

  localparam int N  = 5;
  localparam int NS = 1 << N;

  localparam int ITEM_W [5] = '{12, 1, 2, 1, 4};
  localparam int ITEM_V [5] = '{4, 2, 2, 1, 10};

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  knap_search_ctrl_if #(.N_ITEMS(N)) bus ();

  knap_search_ctrl #(.N_ITEMS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bit          tbl_valid [NS];
  int unsigned tbl_value [NS];

  // Checker stand-in: combinational lookup of the current candidate.
  always_comb begin
    bus.chk_valid = tbl_valid[bus.sel];
`ifdef KNAP_BEST_TRACK_EN
    bus.chk_value = tbl_value[bus.sel];
`endif
  end

  int total  = 0;
  int passed = 0;

  int          exp_count;
  int          exp_first;
  bit          exp_found;
  int          exp_best_sel;
  int unsigned exp_best_val;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic void load_knap();
    for (int s = 0; s < NS; s++) begin
      int tw = 0;
      int tv = 0;
      for (int i = 0; i < 5; i++) begin
        if (((s >> i) & 1) == 1) begin
          tw += ITEM_W[i];
          tv += ITEM_V[i];
        end
      end
      tbl_valid[s] = (tw <= 16) && (tv >= 15);
      tbl_value[s] = tv;
    end
  endfunction

  function automatic void load_const(input bit v);
    for (int s = 0; s < NS; s++) begin
      tbl_valid[s] = v;
      tbl_value[s] = s;
    end
  endfunction

  function automatic void load_pair();
    for (int s = 0; s < NS; s++) begin
      tbl_valid[s] = (s == 7) || (s == 20);
      tbl_value[s] = s;
    end
  endfunction

  function automatic void load_random(input int density);
    for (int s = 0; s < NS; s++) begin
      tbl_valid[s] = ($urandom_range(0, 99) < density);
      tbl_value[s] = $urandom_range(0, 12);
    end
  endfunction

  // Reference: collect feasible indices, then pick the maximum value and its lowest index.
  function automatic void model();
    int hits[$];
    int unsigned vmax;
    hits = {};
    for (int s = 0; s < NS; s++) if (tbl_valid[s]) hits.push_back(s);
    exp_count    = hits.size();
    exp_found    = (hits.size() != 0);
    exp_first    = exp_found ? hits[0] : 0;
    vmax         = 0;
    foreach (hits[k]) if (tbl_value[hits[k]] > vmax) vmax = tbl_value[hits[k]];
    exp_best_val = exp_found ? vmax : 0;
    exp_best_sel = 0;
    for (int k = hits.size() - 1; k >= 0; k--)
      if (tbl_value[hits[k]] == vmax) exp_best_sel = hits[k];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_results(input string tag);
    check({tag, " res_valid"}, bus.res_valid, 1);
    check({tag, " found"}, bus.found, exp_found);
    check({tag, " count"}, bus.count, exp_count);
    check({tag, " first_sel"}, bus.first_sel, exp_first);
`ifdef KNAP_BEST_TRACK_EN
    check({tag, " best_sel"}, bus.best_sel, exp_best_sel);
    check({tag, " best_value"}, bus.best_value, exp_best_val);
`endif
  endtask

  // Full sweep from IDLE; done must appear in cycle 33 counting the start edge as edge 0.
  task automatic run_sweep(input string tag);
    int cyc;
    model();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, " busy at start"}, bus.busy, 1);
    check({tag, " sel at start"}, bus.sel, 0);
    check({tag, " res_valid cleared"}, bus.res_valid, 0);
    cyc = 0;
    for (int i = 1; i <= NS + 8; i++) begin
      tick();
      if (bus.done) begin
        cyc = i + 1;
        break;
      end
    end
    check({tag, " done cycle"}, cyc, NS + 1);
    check({tag, " sel parked"}, bus.sel, NS - 1);
    check_results(tag);
    tick();
    check({tag, " done one cycle"}, bus.done, 0);
    check({tag, " busy after"}, bus.busy, 0);
    check_results({tag, " hold"});
  endtask

  initial begin
    int dones;
    int cyc;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    load_knap();
    #2;
    check("reset sel", bus.sel, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset res_valid", bus.res_valid, 0);
    check("reset found", bus.found, 0);
    check("reset count", bus.count, 0);
    check("reset first_sel", bus.first_sel, 0);
    tick();
    rst = 1'b0;
    tick();

    // Live knapsack instance.
    load_knap();
    run_sweep("knap");
    check("knap spec count", bus.count, 1);
    check("knap spec first", bus.first_sel, 5'b11110);
`ifdef KNAP_BEST_TRACK_EN
    check("knap spec best_sel", bus.best_sel, 5'b11110);
    check("knap spec best_value", bus.best_value, 15);
`endif

    // abort in IDLE leaves held results alone.
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("idle abort res_valid", bus.res_valid, 1);
    check("idle abort busy", bus.busy, 0);

    load_const(1'b1);
    run_sweep("all ones");
    check("all ones count", bus.count, 32);
    load_const(1'b0);
    run_sweep("all zeros");
    check("all zeros found", bus.found, 0);
    load_pair();
    run_sweep("pair");
    check("pair first", bus.first_sel, 7);
`ifdef KNAP_BEST_TRACK_EN
    check("pair best_sel", bus.best_sel, 20);
`endif

    // Abort at RUN cycle 10.
    load_knap();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort busy", bus.busy, 0);
    check("abort res_valid", bus.res_valid, 0);
    dones = 0;
    for (int i = 0; i < NS + 8; i++) begin
      if (bus.done) dones++;
      tick();
    end
    check("abort no done", dones, 0);
    run_sweep("after abort");

    // Abort on the same edge as the last candidate.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < NS; i++) tick();
    check("last sel before abort", bus.sel, NS - 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("late abort done", bus.done, 0);
    check("late abort res_valid", bus.res_valid, 0);
    check("late abort busy", bus.busy, 0);
    tick();
    check("late abort no done later", bus.done, 0);

    // start pulses while busy are ignored.
    load_pair();
    model();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    dones = 0;
    cyc   = 0;
    for (int i = 1; i <= NS + 8; i++) begin
      bus.start = (i == 3) || (i == 20);
      tick();
      if (bus.done) begin
        dones++;
        if (cyc == 0) cyc = i + 1;
      end
    end
    bus.start = 1'b0;
    check("restart dones", dones, 1);
    check("restart done cycle", cyc, NS + 1);
    check_results("restart");

    // start held high through DONE only relaunches from IDLE.
    bus.start = 1'b1;
    tick();
    cyc = 0;
    for (int i = 1; i <= NS + 8; i++) begin
      tick();
      if (bus.done) begin
        cyc = i + 1;
        break;
      end
    end
    check("held start done cycle", cyc, NS + 1);
    tick();
    check("held start idle busy", bus.busy, 0);
    check("held start idle res_valid", bus.res_valid, 1);
    tick();
    check("held start relaunch busy", bus.busy, 1);
    check("held start relaunch res_valid", bus.res_valid, 0);
    bus.start = 1'b0;
    cyc = 0;
    for (int i = 1; i <= NS + 8; i++) begin
      tick();
      if (bus.done) begin
        cyc = i + 1;
        break;
      end
    end
    check("held start second done", cyc, NS + 1);
    tick();

    // Asynchronous reset between clock edges.
    load_knap();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check("async rst sel", bus.sel, 0);
    check("async rst busy", bus.busy, 0);
    check("async rst count", bus.count, 0);
    check("async rst found", bus.found, 0);
    check("async rst first_sel", bus.first_sel, 0);
    check("async rst res_valid", bus.res_valid, 0);
    check("async rst done", bus.done, 0);
    tick();
    rst = 1'b0;
    tick();
    run_sweep("after rst");
    check("after rst first", bus.first_sel, 5'b11110);

    // Randomised checker responses.
    for (int r = 0; r < 5; r++) begin
      load_random((r == 0) ? 3 : 10 + 15 * r);
      run_sweep($sformatf("random %0d", r));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
